// File: rtl/axilite_cfg_master_pkg.sv
// Shared encodings for the AXI-Lite configuration master: command ops, FSM
// states and the FIR accelerator register map.
package axilite_cfg_master_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_POLL  = 2'b10,
    OP_RSVD  = 2'b11
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_RD_REQ,
    ST_POLL_GAP,
    ST_RESP
  } state_e;

  localparam logic [11:0] AP_CTRL  = 12'h000;
  localparam logic [11:0] DATA_LEN = 12'h010;
  localparam logic [11:0] TAP_NUM  = 12'h014;
  localparam logic [11:0] TAP_BASE = 12'h080;

  localparam logic [31:0] AP_START_MSK = 32'h1;
  localparam logic [31:0] AP_DONE_MSK  = 32'h2;
  localparam logic [31:0] AP_IDLE_MSK  = 32'h4;

  // The reserved encoding behaves as a plain READ.
  function automatic cmd_op_e decode_op(input logic [1:0] op);
    case (op)
      2'b00:   return OP_WRITE;
      2'b10:   return OP_POLL;
      default: return OP_READ;
    endcase
  endfunction

endpackage

// File: rtl/axilite_cfg_master.sv
// AXI-Lite initiator turning single WRITE/READ/POLL commands into bus
// transactions, returning one response per command.
module axilite_cfg_master
  import axilite_cfg_master_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int pPOLL_MAX   = 1024,
  parameter int pPOLL_GAP   = 4
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [pADDR_WIDTH-1:0] cmd_addr,
  input  logic [pDATA_WIDTH-1:0] cmd_data,
  input  logic [pDATA_WIDTH-1:0] cmd_mask,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [pDATA_WIDTH-1:0] rsp_data,
  output logic                   rsp_timeout,
  output logic                   awvalid,
  input  logic                   awready,
  output logic [pADDR_WIDTH-1:0] awaddr,
  output logic                   wvalid,
  input  logic                   wready,
  output logic [pDATA_WIDTH-1:0] wdata,
  output logic                   arvalid,
  input  logic                   arready,
  output logic [pADDR_WIDTH-1:0] araddr,
  input  logic                   rvalid,
  output logic                   rready,
  input  logic [pDATA_WIDTH-1:0] rdata
);

  localparam int CNT_W = $clog2(pPOLL_MAX + 1);
  localparam int GAP_W = (pPOLL_GAP > 1) ? $clog2(pPOLL_GAP) : 1;

  state_e                 state_q,       state_d;
  cmd_op_e                op_q,          op_d;
  logic [pADDR_WIDTH-1:0] addr_q,        addr_d;
  logic [pDATA_WIDTH-1:0] data_q,        data_d;
  logic [pDATA_WIDTH-1:0] mask_q,        mask_d;
  logic                   awvalid_q,     awvalid_d;
  logic [pADDR_WIDTH-1:0] awaddr_q,      awaddr_d;
  logic                   wvalid_q,      wvalid_d;
  logic [pDATA_WIDTH-1:0] wdata_q,       wdata_d;
  logic                   aw_done_q,     aw_done_d;
  logic                   w_done_q,      w_done_d;
  logic                   arvalid_q,     arvalid_d;
  logic [pADDR_WIDTH-1:0] araddr_q,      araddr_d;
  logic                   rready_q,      rready_d;
  logic                   ar_done_q,     ar_done_d;
  logic                   r_done_q,      r_done_d;
  logic [pDATA_WIDTH-1:0] rsp_data_q,    rsp_data_d;
  logic                   rsp_timeout_q, rsp_timeout_d;
  logic [CNT_W-1:0]       cnt_q,         cnt_d;
  logic [GAP_W-1:0]       gap_q,         gap_d;

  logic ar_hs;
  logic poll_hit;

  assign ar_hs    = arvalid_q & arready;
  assign poll_hit = ((rsp_data_q & mask_q) == (data_q & mask_q));

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    addr_d        = addr_q;
    data_d        = data_q;
    mask_d        = mask_q;
    awvalid_d     = awvalid_q;
    awaddr_d      = awaddr_q;
    wvalid_d      = wvalid_q;
    wdata_d       = wdata_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    arvalid_d     = arvalid_q;
    araddr_d      = araddr_q;
    rready_d      = rready_q;
    ar_done_d     = ar_done_q;
    r_done_d      = r_done_q;
    rsp_data_d    = rsp_data_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_d         = cnt_q;
    gap_d         = gap_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (cmd_valid) begin
          op_d          = decode_op(cmd_op);
          addr_d        = cmd_addr;
          data_d        = cmd_data;
          mask_d        = cmd_mask;
          rsp_timeout_d = 1'b0;
          aw_done_d     = 1'b0;
          w_done_d      = 1'b0;
          ar_done_d     = 1'b0;
          r_done_d      = 1'b0;
          if (decode_op(cmd_op) == OP_WRITE) begin
            awvalid_d = 1'b1;
            awaddr_d  = cmd_addr;
            wvalid_d  = 1'b1;
            wdata_d   = cmd_data;
            state_d   = ST_WRITE;
          end else begin
            arvalid_d = 1'b1;
            araddr_d  = cmd_addr;
            rready_d  = 1'b1;
            cnt_d     = CNT_W'(1);
            state_d   = ST_RD_REQ;
          end
        end
      end

      // AW and W complete independently, in either order.
      ST_WRITE: begin
        if (awvalid_q && awready) begin
          awvalid_d = 1'b0;
          awaddr_d  = '0;
          aw_done_d = 1'b1;
        end
        if (wvalid_q && wready) begin
          wvalid_d = 1'b0;
          wdata_d  = '0;
          w_done_d = 1'b1;
        end
        if (aw_done_q && w_done_q) begin
          rsp_data_d = '0;
          state_d    = ST_RESP;
        end
      end

      // R beats arriving before the address is accepted are not data.
      ST_RD_REQ: begin
        if (ar_hs) begin
          arvalid_d = 1'b0;
          araddr_d  = '0;
          ar_done_d = 1'b1;
        end
        if (rready_q && rvalid && (ar_done_q || ar_hs)) begin
          rready_d   = 1'b0;
          rsp_data_d = rdata;
          r_done_d   = 1'b1;
        end
        if (r_done_q) begin
          r_done_d  = 1'b0;
          ar_done_d = 1'b0;
          if (op_q != OP_POLL || poll_hit) begin
            state_d = ST_RESP;
          end else if (cnt_q == CNT_W'(pPOLL_MAX)) begin
            rsp_timeout_d = 1'b1;
            state_d       = ST_RESP;
          end else begin
            gap_d   = '0;
            state_d = ST_POLL_GAP;
          end
        end
      end

      ST_POLL_GAP: begin
        if (gap_q == GAP_W'(pPOLL_GAP - 1)) begin
          arvalid_d = 1'b1;
          araddr_d  = addr_q;
          rready_d  = 1'b1;
          cnt_d     = cnt_q + CNT_W'(1);
          state_d   = ST_RD_REQ;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          rsp_timeout_d = 1'b0;
          state_d       = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) begin
      state_q       <= ST_IDLE;
      op_q          <= OP_WRITE;
      addr_q        <= '0;
      data_q        <= '0;
      mask_q        <= '0;
      awvalid_q     <= 1'b0;
      awaddr_q      <= '0;
      wvalid_q      <= 1'b0;
      wdata_q       <= '0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      araddr_q      <= '0;
      rready_q      <= 1'b0;
      ar_done_q     <= 1'b0;
      r_done_q      <= 1'b0;
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
      cnt_q         <= '0;
      gap_q         <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      mask_q        <= mask_d;
      awvalid_q     <= awvalid_d;
      awaddr_q      <= awaddr_d;
      wvalid_q      <= wvalid_d;
      wdata_q       <= wdata_d;
      aw_done_q     <= aw_done_d;
      w_done_q      <= w_done_d;
      arvalid_q     <= arvalid_d;
      araddr_q      <= araddr_d;
      rready_q      <= rready_d;
      ar_done_q     <= ar_done_d;
      r_done_q      <= r_done_d;
      rsp_data_q    <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
      cnt_q         <= cnt_d;
      gap_q         <= gap_d;
    end
  end

  assign cmd_ready   = (state_q == ST_IDLE);
  assign rsp_valid   = (state_q == ST_RESP);
  assign rsp_data    = rsp_data_q;
  assign rsp_timeout = rsp_timeout_q;
  assign awvalid     = awvalid_q;
  assign awaddr      = awaddr_q;
  assign wvalid      = wvalid_q;
  assign wdata       = wdata_q;
  assign arvalid     = arvalid_q;
  assign araddr      = araddr_q;
  assign rready      = rready_q;

endmodule

// File: tb/tb_axilite_cfg_master.sv
// Directed bench for axilite_cfg_master against a small AXI-Lite slave with
// programmable ready/valid delays and an ap_ctrl register that sets ap_done.
module tb_axilite_cfg_master;
  import axilite_cfg_master_pkg::*;

  logic        clk = 1'b0;
  logic        axis_rst_n;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [11:0] cmd_addr;
  logic [31:0] cmd_data, cmd_mask;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] rsp_data;
  logic        awvalid, awready, wvalid, wready, arvalid, arready, rvalid, rready;
  logic [11:0] awaddr, araddr;
  logic [31:0] wdata, rdata;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axilite_cfg_master #(
    .pADDR_WIDTH(12), .pDATA_WIDTH(32), .pPOLL_MAX(8), .pPOLL_GAP(4)
  ) dut (
    .axis_clk(clk), .axis_rst_n(axis_rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_timeout(rsp_timeout),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata)
  );

  // Slave model
  logic [31:0] mem [0:1023];
  int aw_dly = 0, w_dly = 0, ar_dly = 0, r_dly = 1;
  int aw_wait = 0, w_wait = 0, ar_wait = 0, r_cnt = 0;
  int aw_n = 0, w_n = 0, ar_n = 0, aw_hi = 0, w_hi = 0, rr_viol = 0;
  int rd0_cnt = 0, done_at = 32'h7fffffff;
  int ar_cyc [0:255];
  logic        r_pend = 1'b0, aw_got = 1'b0, w_got = 1'b0;
  logic [31:0] r_lat = '0, w_lat = '0;
  logic [11:0] aw_lat = '0;

  function automatic logic [31:0] rd_val(input logic [11:0] a);
    if (a == AP_CTRL) return (rd0_cnt + 1 >= done_at) ? (AP_DONE_MSK | AP_IDLE_MSK) : AP_IDLE_MSK;
    return mem[a[11:2]];
  endfunction

  wire aw_hs = awvalid & awready;
  wire w_hs  = wvalid & wready;
  wire ar_hs = arvalid & arready;
  wire [11:0] wr_a  = aw_hs ? awaddr : aw_lat;
  wire [31:0] wr_d  = w_hs ? wdata : w_lat;
  wire        wr_go = (aw_got | aw_hs) & (w_got | w_hs);

  assign awready = awvalid && (aw_wait >= aw_dly);
  assign wready  = wvalid && (w_wait >= w_dly);
  assign arready = arvalid && (ar_wait >= ar_dly);
  assign rvalid  = (r_dly == 0) ? ar_hs : (r_pend && r_cnt >= r_dly);
  assign rdata   = r_pend ? r_lat : rd_val(araddr);

  always @(posedge clk) begin
    if (awvalid) aw_hi <= aw_hi + 1;
    if (wvalid) w_hi <= w_hi + 1;
    if (aw_hs) aw_n <= aw_n + 1;
    if (w_hs) w_n <= w_n + 1;
    if (r_pend && !rready) rr_viol <= rr_viol + 1;
    if (!axis_rst_n) begin
      aw_wait <= 0; w_wait <= 0; ar_wait <= 0;
      r_pend <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
    end else begin
      aw_wait <= (aw_hs || !awvalid) ? 0 : aw_wait + 1;
      w_wait  <= (w_hs || !wvalid) ? 0 : w_wait + 1;
      ar_wait <= (ar_hs || !arvalid) ? 0 : ar_wait + 1;
      if (ar_hs) begin
        ar_n <= ar_n + 1;
        ar_cyc[ar_n[7:0]] <= cyc;
        if (araddr == AP_CTRL) rd0_cnt <= rd0_cnt + 1;
        if (r_dly != 0) begin
          r_pend <= 1'b1; r_cnt <= 1; r_lat <= rd_val(araddr);
        end
      end else if (r_pend) begin
        if (rvalid && rready) r_pend <= 1'b0;
        else r_cnt <= r_cnt + 1;
      end
      if (wr_go) begin
        mem[wr_a[11:2]] <= wr_d;
        aw_got <= 1'b0; w_got <= 1'b0;
      end else begin
        if (aw_hs) begin aw_got <= 1'b1; aw_lat <= awaddr; end
        if (w_hs) begin w_got <= 1'b1; w_lat <= wdata; end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] data,
                        input logic [31:0] mask, input int hold,
                        output logic [31:0] rd, output logic tmo, output int lat);
    int a_cyc;
    bit to;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_mask = mask;
    to = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (cmd_ready) begin to = 1'b0; break; end
      @(negedge clk);
    end
    a_cyc = cyc;
    chk("cmd_accept_timeout", 32'(to), 32'd0);
    @(negedge clk);
    cmd_valid = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 500; i++) begin
      if (rsp_valid) begin to = 1'b0; break; end
      @(negedge clk);
    end
    lat = cyc - a_cyc;
    chk("rsp_timeout_wait", 32'(to), 32'd0);
    repeat (hold) @(negedge clk);
    if (hold > 0) chk("rsp_valid_held", 32'(rsp_valid), 32'd1);
    rd = rsp_data; tmo = rsp_timeout;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("cmd_ready_after_rsp", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    logic        tmo;
    int          lat, a0, w0, r0, ah0, wh0, v0;
    logic [31:0] coef [0:31];
    logic [7:0]  ix;

    axis_rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = '0;
    cmd_data = '0; cmd_mask = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_valids", {28'd0, awvalid, wvalid, arvalid, rready}, 32'd0);
    chk("rst_rsp", {30'd0, rsp_valid, rsp_timeout}, 32'd0);
    chk("rst_addr_data", {20'd0, awaddr} | {20'd0, araddr} | wdata | rsp_data, 32'd0);
    axis_rst_n = 1'b1;

    // WRITE 0x10 <- 400, awready immediately, wready after two waits
    aw_dly = 0; w_dly = 2; ah0 = aw_hi; wh0 = w_hi; a0 = aw_n;
    do_cmd(OP_WRITE, DATA_LEN, 32'd400, 32'd0, 0, rd, tmo, lat);
    chk("wr_rsp_data", rd, 32'd0);
    chk("wr_lat", 32'(lat), 32'd5);
    chk("wr_aw_cycles", 32'(aw_hi - ah0), 32'd1);
    chk("wr_w_cycles", 32'(w_hi - wh0), 32'd3);
    chk("wr_aw_beats", 32'(aw_n - a0), 32'd1);
    chk("wr_mem_0x10", mem[4], 32'd400);
    w_dly = 0;

    // Coefficient load and readback
    a0 = aw_n; w0 = w_n; r0 = ar_n;
    for (int k = 0; k < 32; k++) begin
      coef[k] = 32'(k * 37 + 5) ^ 32'h0001_0000;
      do_cmd(OP_WRITE, TAP_BASE + 12'(4 * k), coef[k], 32'd0, 0, rd, tmo, lat);
      if (k == 0) chk("coef_wr_lat", 32'(lat), 32'd3);
    end
    for (int k = 0; k < 32; k++) begin
      do_cmd(OP_READ, TAP_BASE + 12'(4 * k), 32'd0, 32'd0, 0, rd, tmo, lat);
      chk($sformatf("coef_rd_%0d", k), rd, coef[k]);
      if (k == 0) chk("coef_rd_lat", 32'(lat), 32'd4);
    end
    chk("coef_aw_beats", 32'(aw_n - a0), 32'd32);
    chk("coef_w_beats", 32'(w_n - w0), 32'd32);
    chk("coef_ar_beats", 32'(ar_n - r0), 32'd32);

    // Reserved opcode behaves as READ
    do_cmd(2'b11, TAP_BASE + 12'h004, 32'd0, 32'd0, 0, rd, tmo, lat);
    chk("rsvd_as_read", rd, coef[1]);

    // rvalid in the same cycle as arready, response held two cycles
    r_dly = 0;
    do_cmd(OP_READ, DATA_LEN, 32'd0, 32'd0, 2, rd, tmo, lat);
    chk("rd_same_cycle", rd, 32'd400);
    chk("rd_same_cycle_lat", 32'(lat), 32'd3);

    // rvalid five cycles after arready
    r_dly = 5; v0 = rr_viol;
    do_cmd(OP_READ, DATA_LEN, 32'd0, 32'd0, 0, rd, tmo, lat);
    chk("rd_slow", rd, 32'd400);
    chk("rd_slow_lat", 32'(lat), 32'd8);
    chk("rd_slow_rready_held", 32'(rr_viol - v0), 32'd0);
    r_dly = 1;

    // POLL ap_done, set on the third read
    done_at = rd0_cnt + 3; r0 = ar_n;
    do_cmd(OP_POLL, AP_CTRL, AP_DONE_MSK, AP_DONE_MSK, 0, rd, tmo, lat);
    chk("poll_ar_beats", 32'(ar_n - r0), 32'd3);
    chk("poll_timeout", 32'(tmo), 32'd0);
    chk("poll_done_bit", 32'(rd[1]), 32'd1);
    chk("poll_rsp_data", rd, 32'h6);
    for (int i = 1; i < 3; i++) begin
      ix = 8'(r0 + i);
      chk($sformatf("poll_gap_%0d", i), 32'((ar_cyc[ix] - ar_cyc[ix - 8'd1] - 1) >= 4), 32'd1);
    end

    // POLL that never completes
    done_at = 32'h7fffffff; r0 = ar_n;
    do_cmd(OP_POLL, AP_CTRL, AP_DONE_MSK, AP_DONE_MSK, 0, rd, tmo, lat);
    chk("poll_to_ar_beats", 32'(ar_n - r0), 32'd8);
    chk("poll_to_timeout", 32'(tmo), 32'd1);
    chk("poll_to_rsp_data", rd, AP_IDLE_MSK);

    // Reset while a write is stalled on AW and W
    aw_dly = 20; w_dly = 20;
    @(negedge clk);
    chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_op = OP_WRITE; cmd_addr = TAP_NUM; cmd_data = 32'hdead;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("abort_valids_up", {30'd0, awvalid, wvalid}, 32'd3);
    axis_rst_n = 1'b0;
    @(negedge clk);
    axis_rst_n = 1'b1;
    chk("abort_valids_down", {28'd0, awvalid, wvalid, arvalid, rready}, 32'd0);
    chk("abort_cmd_ready_up", 32'(cmd_ready), 32'd1);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    aw_dly = 0; w_dly = 0;
    do_cmd(OP_WRITE, TAP_NUM, 32'd32, 32'd0, 0, rd, tmo, lat);
    chk("post_abort_lat", 32'(lat), 32'd3);
    chk("post_abort_rsp", rd, 32'd0);
    chk("post_abort_mem", mem[5], 32'd32);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axilite_cfg_master.md
Name: axilite_cfg_master

Overview:
- AXI-Lite initiator that drives the configuration port of an accelerator such as the FIR (ap_ctrl at 0x00, lengths at 0x10/0x14, taps from 0x80).
- Accepts single commands (WRITE, READ, POLL) on a valid/ready command port.
- Performs the AXI-Lite transaction and returns one response per command.
- Lets on-chip firmware or sequencers program and start the accelerator, then wait for ap_done, with no testbench tasks in the loop.

Parameters:
- pADDR_WIDTH, 12, AXI-Lite address width.
- pDATA_WIDTH, 32, AXI-Lite data width.
- pPOLL_MAX, 1024, maximum read attempts per POLL command before timeout.
- pPOLL_GAP, 4, idle cycles between consecutive POLL reads.

Ports:
- axis_clk  in  1  clock.
- axis_rst_n  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_op  in  2  00 WRITE, 01 READ, 10 POLL, 11 reserved (treated as READ).
- cmd_addr  in  pADDR_WIDTH  target address.
- cmd_data  in  pDATA_WIDTH  write data (WRITE) or expected value (POLL).
- cmd_mask  in  pDATA_WIDTH  compare mask (POLL only).
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed.
- rsp_data  out  pDATA_WIDTH  last read data; 0 for WRITE.
- rsp_timeout  out  1  POLL exhausted pPOLL_MAX attempts.
- awvalid/awready/awaddr  out/in/out  1/1/pADDR_WIDTH  write address channel.
- wvalid/wready/wdata  out/in/out  1/1/pDATA_WIDTH  write data channel.
- arvalid/arready/araddr  out/in/out  1/1/pADDR_WIDTH  read address channel.
- rvalid/rready/rdata  in/out/in  1/1/pDATA_WIDTH  read data channel.

Behaviour:
- Reset values: all valids, rready, rsp_valid, rsp_timeout = 0; all addr/data outputs = 0; cmd_ready = 1; FSM in IDLE.
- Reset mid-transaction abandons the transaction and immediately drops all valids. There is no B channel; a write is complete when both AW and W handshakes have occurred.
- States: IDLE, WRITE, RD_REQ, POLL_GAP, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, register op/addr/data/mask and drop cmd_ready.
  - WRITE: next cycle raise awvalid and wvalid, go to WRITE.
  - READ/POLL: next cycle raise arvalid and rready, go to RD_REQ.
  - Poll counter cleared.
- WRITE:
  - Track aw_done and w_done independently.
  - awvalid drops the cycle after awvalid&awready; wvalid drops the cycle after wvalid&wready; either order or simultaneous.
  - awaddr/wdata return to 0 when their valid drops.
  - When both are done, go to RESP with rsp_data = 0.
- RD_REQ:
  - arvalid drops after arvalid&arready.
  - rready stays high until rvalid&rready; rdata is captured that cycle.
  - rvalid in the same cycle as arready is legal and captured.
  - rvalid before the AR handshake is ignored.
  - READ: go to RESP.
  - POLL, with count = attempts including the current one:
    - if (rdata & mask) == (data & mask), go to RESP with timeout = 0;
    - else if count == pPOLL_MAX, go to RESP with timeout = 1;
    - else go to POLL_GAP.
- POLL_GAP: wait exactly pPOLL_GAP cycles with all valids low, then reissue arvalid/rready and return to RD_REQ.
- RESP:
  - rsp_valid = 1; rsp_data and rsp_timeout are held stable until rsp_valid&rsp_ready.
  - Then return to IDLE; cmd_ready is high the following cycle.
  - Only one command is outstanding at a time.
- Latency with zero-wait slave:
  - WRITE: cmd accept to rsp_valid = 3 cycles.
  - READ with rvalid one cycle after arready: 4 cycles.
- Address and data outputs are registered and stable while their valid is high.
- The counter is wide enough for pPOLL_MAX; it does not wrap.

Decomposition:
- Shared package holds:
  - op encodings (OP_WRITE, OP_READ, OP_POLL);
  - FSM state typedef;
  - FIR register map constants: AP_CTRL 0x00, DATA_LEN 0x10, TAP_NUM 0x14, TAP_BASE 0x80;
  - ap_start/ap_done/ap_idle bit masks 0x1/0x2/0x4.
- Single module.
- Optional sub-module axilite_cfg_master_poll_ctr (counter plus gap timer) if kept separate; otherwise inline.

Test Plan:
- WRITE 0x10 ← 400 against a slave with awready at cycle 1 and wready at cycle 3: awvalid drops after cycle 1, wvalid after cycle 3, one rsp_valid with rsp_data = 0. Slave register 0x10 = 400.
- Coefficient load: 32 WRITEs to 0x80+4k, then 32 READs. Every rsp_data equals the written coef[k]; no extra AXI beats.
- READ with rvalid in the same cycle as arready: rsp_data = slave value. Separately, rvalid 5 cycles later: same result, rready held high throughout.
- POLL 0x00, data 0x2, mask 0x2, with ap_done set after the 3rd read: exactly 3 AR handshakes, with ≥pPOLL_GAP idle cycles between them. rsp_timeout = 0, rsp_data bit 1 = 1.
- POLL with ap_done never set, pPOLL_MAX = 8: exactly 8 reads, then rsp_timeout = 1.
- axis_rst_n low for 1 cycle while awvalid/wvalid are high: next cycle all valids = 0, cmd_ready = 1. A subsequent WRITE completes normally.
